// File: rtl/memcard_bank.sv
// NeoGeo memory-card RAM: byte-wide 68k port plus word-wide HPS save/load port on one RAM.
// Latency: 68k read data 1 cycle after CARD_CE; HPS access acks 2 cycles after a CE-free request.
// Backpressure: 68k owns the RAM whenever CARD_CE=1; the HPS request stalls until CE drops.
module memcard_bank #(
  parameter int ADDR_W    = 13,
  parameter int CART_W    = 11,
  parameter int BLK_W     = 8,
  parameter int EJECT_CYC = 1024
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              SYSTEM_CDx,
  input  logic [ADDR_W-1:0] CDA,
  input  logic              CARD_CE,
  input  logic              CARD_WE,
  input  logic [7:0]        M68K_DATA,
  output logic [7:0]        CDD,
  input  logic              CARD_WP,
  output logic              CARD_DETECT,
  input  logic              img_load,
  input  logic              img_eject,
  input  logic              hps_req,
  input  logic              hps_we,
  input  logic [ADDR_W-2:0] hps_addr,
  input  logic [15:0]       hps_din,
  output logic [15:0]       hps_dout,
  output logic              hps_ack,
  output logic              dirty_any,
  input  logic              dirty_clr
);

  localparam int LANE_W = ADDR_W - 1;
  localparam int DEPTH  = 1 << LANE_W;
  localparam int NBLK   = 1 << (ADDR_W - BLK_W);
  localparam int CNT_W  = $clog2(EJECT_CYC + 1);
  localparam logic [ADDR_W-1:0] CART_MASK = {ADDR_W{1'b1}} >> (ADDR_W - CART_W);

  typedef enum logic [1:0] {CARD_EMPTY, CARD_PRESENT, CARD_EJECTING} card_state_t;
  typedef enum logic [1:0] {HPS_IDLE, HPS_ACCESS, HPS_ACKED} hps_state_t;

  // Even bytes live in the upper lane (big-endian 68k view of a 16-bit word).
  logic [7:0] ram_hi [DEPTH];
  logic [7:0] ram_lo [DEPTH];

  card_state_t       card_state;
  logic [CNT_W-1:0]  eject_cnt;
  hps_state_t        hps_state;
  logic              hps_we_q;
  logic [LANE_W-1:0] hps_addr_q;
  logic [15:0]       hps_din_q;
  logic [NBLK-1:0]   dirty;
  logic [NBLK-1:0]   dirty_set;

  logic [ADDR_W-1:0] cda_m;
  logic [LANE_W-1:0] cpu_idx;
  logic              cpu_wr;
  logic              hps_go;
  logic              hps_wr;

  // Cart mode only decodes the low CART_W address bits; the rest alias to zero.
  assign cda_m   = SYSTEM_CDx ? CDA : (CDA & CART_MASK);
  assign cpu_idx = cda_m[ADDR_W-1:1];
  assign cpu_wr  = CARD_CE & CARD_WE & ~CARD_WP & (card_state == CARD_PRESENT);
  assign hps_go  = (hps_state == HPS_ACCESS) & ~CARD_CE;
  assign hps_wr  = hps_go & hps_we_q;

  // RAM write port: 68k and HPS never write together since HPS only goes when CE=0.
  always_ff @(posedge CLK) begin
    if (cpu_wr) begin
      if (cda_m[0]) ram_lo[cpu_idx] <= M68K_DATA;
      else          ram_hi[cpu_idx] <= M68K_DATA;
    end else if (hps_wr) begin
      ram_hi[hps_addr_q] <= hps_din_q[15:8];
      ram_lo[hps_addr_q] <= hps_din_q[7:0];
    end
  end

  // 68k read data is registered and held between accesses; writes still return old data.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      CDD <= 8'h00;
    end else if (CARD_CE) begin
      CDD <= cda_m[0] ? ram_lo[cpu_idx] : ram_hi[cpu_idx];
    end
  end

  // HPS handshake: latch the request, wait for a CE-free cycle, then pulse ack.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      hps_state  <= HPS_IDLE;
      hps_we_q   <= 1'b0;
      hps_addr_q <= '0;
      hps_din_q  <= 16'h0000;
      hps_dout   <= 16'h0000;
      hps_ack    <= 1'b0;
    end else begin
      hps_ack <= 1'b0;
      case (hps_state)
        HPS_IDLE: begin
          if (hps_req && !CARD_CE) begin
            hps_we_q   <= hps_we;
            hps_addr_q <= hps_addr;
            hps_din_q  <= hps_din;
            hps_state  <= HPS_ACCESS;
          end
        end
        HPS_ACCESS: begin
          if (hps_go) begin
            hps_dout  <= hps_we_q ? hps_din_q : {ram_hi[hps_addr_q], ram_lo[hps_addr_q]};
            hps_ack   <= 1'b1;
            hps_state <= HPS_ACKED;
          end
        end
        HPS_ACKED: hps_state <= HPS_IDLE;
        default:   hps_state <= HPS_IDLE;
      endcase
    end
  end

  // Card presence: a reload while present drops CARD_DETECT for EJECT_CYC cycles so the
  // 68k side sees a swap; eject always wins over load.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      card_state  <= CARD_EMPTY;
      eject_cnt   <= '0;
      CARD_DETECT <= 1'b0;
    end else begin
      case (card_state)
        CARD_EMPTY: begin
          if (img_load && !img_eject) begin
            card_state  <= CARD_PRESENT;
            CARD_DETECT <= 1'b1;
          end
        end
        CARD_PRESENT: begin
          if (img_eject) begin
            card_state  <= CARD_EMPTY;
            CARD_DETECT <= 1'b0;
          end else if (img_load) begin
            card_state  <= CARD_EJECTING;
            eject_cnt   <= '0;
            CARD_DETECT <= 1'b0;
          end
        end
        CARD_EJECTING: begin
          if (img_eject) begin
            card_state <= CARD_EMPTY;
            eject_cnt  <= '0;
          end else if (eject_cnt == CNT_W'(EJECT_CYC - 1)) begin
            card_state  <= CARD_PRESENT;
            eject_cnt   <= '0;
            CARD_DETECT <= 1'b1;
          end else begin
            eject_cnt <= eject_cnt + 1'b1;
          end
        end
        default: begin
          card_state  <= CARD_EMPTY;
          eject_cnt   <= '0;
          CARD_DETECT <= 1'b0;
        end
      endcase
    end
  end

  // One-hot block mark for the accepted 68k write this cycle.
  always_comb begin
    dirty_set = '0;
    if (cpu_wr) dirty_set[cda_m[ADDR_W-1:BLK_W]] = 1'b1;
  end

  // Dirty tracking: a set in the same cycle as a clear survives the clear.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      dirty     <= '0;
      dirty_any <= 1'b0;
    end else begin
      dirty     <= (dirty_clr ? '0 : dirty) | dirty_set;
      dirty_any <= |dirty;
    end
  end

endmodule

// File: tb/tb_memcard_bank.sv
// Scoreboard bench for memcard_bank: directed 68k/HPS traffic, card sequencing, dirty tracking.
// Latency: expected CDD one cycle after a read, hps_dout with hps_ack.
// Backpressure: HPS requests are held until ack, bounded by a cycle budget.
module tb_memcard_bank;

  logic        CLK = 1'b0;
  logic        nRESET;
  logic        SYSTEM_CDx;
  logic [12:0] CDA;
  logic        CARD_CE;
  logic        CARD_WE;
  logic [7:0]  M68K_DATA;
  logic [7:0]  CDD;
  logic        CARD_WP;
  logic        CARD_DETECT;
  logic        img_load;
  logic        img_eject;
  logic        hps_req;
  logic        hps_we;
  logic [11:0] hps_addr;
  logic [15:0] hps_din;
  logic [15:0] hps_dout;
  logic        hps_ack;
  logic        dirty_any;
  logic        dirty_clr;

  typedef struct packed {
    logic [15:0] exp;
    logic [15:0] mask;
  } hps_exp_t;

  logic [7:0] cdd_q [$];
  hps_exp_t   hps_q [$];
  int         n_chk  = 0;
  int         n_pass = 0;
  logic       rd_seen = 1'b0;

  always #5 CLK = ~CLK;

  memcard_bank #(.ADDR_W(13), .CART_W(11), .BLK_W(8), .EJECT_CYC(1024)) dut (
    .CLK(CLK), .nRESET(nRESET), .SYSTEM_CDx(SYSTEM_CDx), .CDA(CDA),
    .CARD_CE(CARD_CE), .CARD_WE(CARD_WE), .M68K_DATA(M68K_DATA), .CDD(CDD),
    .CARD_WP(CARD_WP), .CARD_DETECT(CARD_DETECT), .img_load(img_load),
    .img_eject(img_eject), .hps_req(hps_req), .hps_we(hps_we), .hps_addr(hps_addr),
    .hps_din(hps_din), .hps_dout(hps_dout), .hps_ack(hps_ack),
    .dirty_any(dirty_any), .dirty_clr(dirty_clr)
  );

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Remember which edges carried a 68k read so the monitor knows when CDD is due.
  always @(posedge CLK) rd_seen <= CARD_CE & ~CARD_WE;

  // Monitor: pop and compare whenever the DUT presents read data or an HPS ack.
  always @(negedge CLK) begin
    if (rd_seen) begin
      if (cdd_q.size() == 0) begin
        n_chk++;
        $display("FAIL cdd_unexpected: got 0x%0h with no expected read", CDD);
      end else begin
        check("cdd", int'(CDD), int'(cdd_q.pop_front()));
      end
    end
    if (hps_ack) begin
      if (hps_q.size() == 0) begin
        n_chk++;
        $display("FAIL hps_ack_unexpected: got ack with dout 0x%0h", hps_dout);
      end else begin
        hps_exp_t e;
        e = hps_q.pop_front();
        if (e.mask != 16'h0000)
          check("hps_dout", int'(hps_dout & e.mask), int'(e.exp & e.mask));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr68(input logic [12:0] a, input logic [7:0] d, input logic clr = 1'b0);
    CDA = a; M68K_DATA = d; CARD_CE = 1'b1; CARD_WE = 1'b1; dirty_clr = clr;
    tick();
    CARD_CE = 1'b0; CARD_WE = 1'b0; dirty_clr = 1'b0;
  endtask

  task automatic rd68(input logic [12:0] a, input logic [7:0] exp);
    cdd_q.push_back(exp);
    CDA = a; CARD_CE = 1'b1; CARD_WE = 1'b0;
    tick();
    CARD_CE = 1'b0;
  endtask

  task automatic hps_op(input logic we, input logic [11:0] a, input logic [15:0] d,
                        input logic [15:0] exp, input logic [15:0] mask);
    bit got;
    got = 1'b0;
    hps_q.push_back('{exp: exp, mask: mask});
    hps_we = we; hps_addr = a; hps_din = d; hps_req = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (hps_ack) begin
        got = 1'b1;
        break;
      end
    end
    hps_req = 1'b0;
    if (!got) begin
      n_chk++;
      $display("FAIL hps_timeout: got no ack in 50 cycles, expected ack");
    end
  endtask

  task automatic pulse_load();
    img_load = 1'b1;
    tick();
    img_load = 1'b0;
  endtask

  task automatic clear_dirty();
    dirty_clr = 1'b1;
    tick();
    dirty_clr = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acks;
    nRESET = 1'b0; SYSTEM_CDx = 1'b1; CDA = '0; CARD_CE = 1'b0; CARD_WE = 1'b0;
    M68K_DATA = '0; CARD_WP = 1'b0; img_load = 1'b0; img_eject = 1'b0;
    hps_req = 1'b0; hps_we = 1'b0; hps_addr = '0; hps_din = '0; dirty_clr = 1'b0;
    #12;
    check("rst_cdd", int'(CDD), 0);
    check("rst_hps_dout", int'(hps_dout), 0);
    check("rst_hps_ack", int'(hps_ack), 0);
    check("rst_detect", int'(CARD_DETECT), 0);
    check("rst_dirty_any", int'(dirty_any), 0);
    @(posedge CLK); #1;
    nRESET = 1'b1;
    tick();

    // CD mode, top byte of the card, read back over both ports.
    pulse_load();
    check("detect_after_load", int'(CARD_DETECT), 1);
    wr68(13'h1FFF, 8'hA5);
    check("dirty_lag", int'(dirty_any), 0);
    tick();
    check("dirty_set", int'(dirty_any), 1);
    hps_op(1'b0, 12'hFFF, 16'h0000, 16'h00A5, 16'h00FF);
    rd68(13'h1FFF, 8'hA5);

    // Cart mode aliases high address bits to zero.
    SYSTEM_CDx = 1'b0;
    wr68(13'h1801, 8'h3C);
    rd68(13'h0001, 8'h3C);
    rd68(13'h1801, 8'h3C);
    hps_op(1'b0, 12'h000, 16'h0000, 16'h003C, 16'h00FF);
    SYSTEM_CDx = 1'b1;
    rd68(13'h1FFF, 8'hA5);
    rd68(13'h0001, 8'h3C);

    // Write protect blocks 68k writes and dirty marks; HPS ignores it and wins by order.
    wr68(13'h0010, 8'h12);
    clear_dirty();
    check("dirty_cleared_wp", int'(dirty_any), 0);
    CARD_WP = 1'b1;
    wr68(13'h0010, 8'h55);
    tick();
    tick();
    check("wp_no_dirty", int'(dirty_any), 0);
    rd68(13'h0010, 8'h12);
    hps_op(1'b1, 12'h008, 16'hBEEF, 16'h0000, 16'h0000);
    rd68(13'h0010, 8'hBE);
    rd68(13'h0011, 8'hEF);
    CARD_WP = 1'b0;

    // HPS request stalled by 10 cycles of 68k reads, then acks 2 cycles after CE drops.
    hps_q.push_back('{exp: 16'hBEEF, mask: 16'hFFFF});
    CDA = 13'h0010; CARD_CE = 1'b1; CARD_WE = 1'b0;
    hps_req = 1'b1; hps_we = 1'b0; hps_addr = 12'h008;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      cdd_q.push_back(8'hBE);
      tick();
      if (hps_ack) acks++;
    end
    check("no_ack_while_ce", acks, 0);
    CARD_CE = 1'b0;
    tick();
    check("ack_not_after_1cyc", int'(hps_ack), 0);
    tick();
    check("ack_after_2cyc", int'(hps_ack), 1);
    hps_req = 1'b0;
    tick();

    // Dirty set coincident with clear survives; a later lone clear empties it.
    clear_dirty();
    check("dirty_cleared", int'(dirty_any), 0);
    wr68(13'h0500, 8'h01);
    tick();
    check("dirty_blk5", int'(dirty_any), 1);
    wr68(13'h0305, 8'h02, 1'b1);
    tick();
    tick();
    check("set_beats_clr", int'(dirty_any), 1);
    clear_dirty();
    check("dirty_clr_after", int'(dirty_any), 0);

    // Writes during the eject window are dropped.
    wr68(13'h0020, 8'h11);
    pulse_load();
    check("eject_start", int'(CARD_DETECT), 0);
    repeat (5) tick();
    wr68(13'h0020, 8'h77);
    n = 0;
    while (!CARD_DETECT && n < 1100) begin
      tick();
      n++;
    end
    check("detect_back", int'(CARD_DETECT), 1);
    rd68(13'h0020, 8'h11);

    // Exact eject window length.
    img_load = 1'b1;
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      img_load = 1'b0;
      if (CARD_DETECT) break;
      n++;
    end
    check("eject_len", n, 1024);

    // Eject to EMPTY, writes dropped, reload; eject beats a simultaneous load.
    img_eject = 1'b1;
    tick();
    img_eject = 1'b0;
    check("eject_detect", int'(CARD_DETECT), 0);
    wr68(13'h0020, 8'h99);
    pulse_load();
    check("reload_detect", int'(CARD_DETECT), 1);
    rd68(13'h0020, 8'h11);
    img_load = 1'b1; img_eject = 1'b1;
    tick();
    img_load = 1'b0; img_eject = 1'b0;
    check("eject_beats_load", int'(CARD_DETECT), 0);
    pulse_load();
    check("load_after_eject", int'(CARD_DETECT), 1);

    // Reset in the middle of an eject lands in EMPTY, not back in PRESENT.
    pulse_load();
    repeat (100) tick();
    nRESET = 1'b0;
    #1;
    check("rst_mid_detect", int'(CARD_DETECT), 0);
    check("rst_mid_cdd", int'(CDD), 0);
    tick();
    nRESET = 1'b1;
    repeat (1100) tick();
    check("empty_after_rst", int'(CARD_DETECT), 0);
    pulse_load();
    check("load_after_rst", int'(CARD_DETECT), 1);

    repeat (3) tick();
    check("cdd_queue_drained", cdd_q.size(), 0);
    check("hps_queue_drained", hps_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
